// File: rtl/seven_segment_mux.sv
// Multiplexed seven-segment driver: binary value -> BCD (double dabble)
// or hex, scanned across DIGITS common-anode digits.
//
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   data, load      : value to display, one-cycle capture strobe
//   hex_mode, dp_in : captured with load (radix, per-digit decimal points)
//   blank_lz        : live leading-zero blanking enable
//   busy            : conversion running, load ignored
//   seg, an, dp     : registered, active-low segment/anode/point drives
module seven_segment_mux #(
  parameter int DIGITS   = 4,
  parameter int DATA_W   = 8,
  parameter int PRESCALE = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data,
  input  logic              load,
  input  logic              hex_mode,
  input  logic              blank_lz,
  input  logic [DIGITS-1:0] dp_in,
  output logic              busy,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an,
  output logic              dp
);

  localparam int BW = 4 * DIGITS;
  localparam int XW = (DATA_W > BW) ? DATA_W : BW;
  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int SW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic {
    IDLE,
    CONV
  } state_t;

  state_t state, state_n;

  logic [CW-1:0]     cnt;
  logic              accept;
  logic [DATA_W-1:0] sreg, sreg_n;
  logic [BW-1:0]     bcd, bcd_adj, bcd_n;
  logic              ovf_acc, dec_ovf;
  logic              hex_q;
  logic [DIGITS-1:0] mask_q;
  logic [XW-1:0]     sx;
  logic [BW-1:0]     hex_dig;
  logic              hex_ovf;

  logic [BW-1:0]     disp;
  logic              disp_ovf;
  logic [DIGITS-1:0] disp_mask;

  logic [PW-1:0]     presc;
  logic [SW-1:0]     slot;
  logic [3:0]        cur;
  logic              cur_dp;
  logic              upper_nz;
  logic              blanked;
  logic [DIGITS-1:0] an_n;
  logic [6:0]        seg_n;
  logic              dp_n;

  function automatic logic [6:0] glyph(input logic [3:0] v);
    logic [6:0] g;
    unique case (v)
      4'h0: g = 7'b1000000;
      4'h1: g = 7'b1111001;
      4'h2: g = 7'b0100100;
      4'h3: g = 7'b0110000;
      4'h4: g = 7'b0011001;
      4'h5: g = 7'b0010010;
      4'h6: g = 7'b0000010;
      4'h7: g = 7'b1111000;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0010000;
      4'ha: g = 7'b0001000;
      4'hb: g = 7'b0000011;
      4'hc: g = 7'b1000110;
      4'hd: g = 7'b0100001;
      4'he: g = 7'b0000110;
      4'hf: g = 7'b0001110;
    endcase
    return g;
  endfunction

  assign busy   = (state == CONV);
  assign accept = load & ~busy;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (accept) state_n = CONV;
      CONV: if (cnt == '0) state_n = IDLE;
    endcase
  end

  // One double-dabble step; the bit leaving the top nibble
  // means the value needs more digits than we have.
  always_comb begin
    for (int k = 0; k < DIGITS; k++) begin
      if (bcd[4*k +: 4] > 4'd4)
        bcd_adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
      else
        bcd_adj[4*k +: 4] = bcd[4*k +: 4];
    end
    bcd_n   = {bcd_adj[BW-2:0], sreg[DATA_W-1]};
    sreg_n  = sreg << 1;
    dec_ovf = ovf_acc | bcd_adj[BW-1];
    sx      = XW'(sreg);
    hex_dig = sx[BW-1:0];
    hex_ovf = |(sx >> BW);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      sreg      <= '0;
      bcd       <= '0;
      ovf_acc   <= 1'b0;
      hex_q     <= 1'b0;
      mask_q    <= '0;
      disp      <= '0;
      disp_ovf  <= 1'b0;
      disp_mask <= '0;
    end else if (accept) begin
      cnt     <= hex_mode ? '0 : CW'(DATA_W - 1);
      sreg    <= data;
      bcd     <= '0;
      ovf_acc <= 1'b0;
      hex_q   <= hex_mode;
      mask_q  <= dp_in;
    end else if (busy) begin
      if (hex_q) begin
        disp      <= hex_dig;
        disp_ovf  <= hex_ovf;
        disp_mask <= mask_q;
      end else begin
        bcd     <= bcd_n;
        sreg    <= sreg_n;
        ovf_acc <= dec_ovf;
        cnt     <= cnt - CW'(1);
        if (cnt == '0) begin
          disp      <= bcd_n;
          disp_ovf  <= dec_ovf;
          disp_mask <= mask_q;
        end
      end
    end
  end

  always_comb begin
    cur      = '0;
    cur_dp   = 1'b0;
    upper_nz = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (SW'(k) == slot) begin
        cur    = disp[4*k +: 4];
        cur_dp = disp_mask[k];
      end
      if (SW'(k) >= slot && disp[4*k +: 4] != 4'd0)
        upper_nz = 1'b1;
    end
    blanked = blank_lz & (slot != '0) & ~upper_nz;
    an_n    = ~(DIGITS'(1) << slot);
    seg_n   = glyph(cur);
    dp_n    = ~cur_dp;
    if (disp_ovf) begin
      seg_n = 7'b0111111;
      dp_n  = 1'b1;
    end else if (blanked) begin
      an_n  = '1;
      seg_n = 7'b1111111;
      dp_n  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc <= '0;
      slot  <= '0;
      an    <= '1;
      seg   <= 7'b1111111;
      dp    <= 1'b1;
    end else begin
      if (presc == PW'(PRESCALE - 1)) begin
        presc <= '0;
        if (slot == SW'(DIGITS - 1)) slot <= '0;
        else                         slot <= slot + SW'(1);
      end else begin
        presc <= presc + PW'(1);
      end
      an  <= an_n;
      seg <= seg_n;
      dp  <= dp_n;
    end
  end

endmodule
